// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, sync-bundle type and the renderer's BGR nibble split.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic DEF_SYNC_POL = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Renderer packs {b,g,r}; the pins want them in {r,g,b} order.
  function automatic logic [11:0] bgr_split(input logic [11:0] bgr);
    return {bgr[3:0], bgr[7:4], bgr[11:8]};
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register that delays {hsync, vsync, de} to match the renderer latency.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int   DEPTH    = 1,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] sync_in,
  output logic [2:0] sync_out
);

  localparam logic [2:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [2:0] stage [DEPTH];

  // NOTE: every stage is reset here on purpose -- a few flops, and stale
  // de/sync bits would otherwise leak onto the pins after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
    end else if (tick) begin
      stage[0] <= sync_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign sync_out = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing source: pixel-tick divider, raster counters, renderer
// latency alignment and the once-per-frame vertical-blank pulse.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   PIPE_LAT = 1,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             line_end;
  sync_t            raw;
  logic [2:0]       delayed;
  sync_t            dly;

  assign tick     = (div_cnt == DIV_LAST);
  assign line_end = (h_cnt == H_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Registered so it rises on the first tick of vertical blank, one clk wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= tick && line_end && (v_cnt == V_ACT_LAST);
  end

  // NOTE: defaults come first so no path through this block infers a latch.
  always_comb begin
    raw.hs = ~SYNC_POL;
    raw.vs = ~SYNC_POL;
    raw.de = 1'b0;
    if (h_cnt >= HS_BEG && h_cnt < HS_END) raw.hs = SYNC_POL;
    if (v_cnt >= VS_BEG && v_cnt < VS_END) raw.vs = SYNC_POL;
    if (h_cnt < H_ACT && v_cnt < V_ACT)    raw.de = 1'b1;
  end

  assign pix_valid = raw.de;
  assign pix_x     = raw.de ? h_cnt : '0;
  assign pix_y     = raw.de ? v_cnt[8:0] : '0;

  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign delayed = raw;
    end else begin : g_delay
      vga_sync_delay #(
        .DEPTH    (PIPE_LAT),
        .SYNC_POL (SYNC_POL)
      ) u_sync_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sync_in  (raw),
        .sync_out (delayed)
      );
    end
  endgenerate

  assign dly = sync_t'(delayed);

  // Output register: rgb_in arrives on the same tick as its delayed de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      {vga_r, vga_g, vga_b} <= '0;
    end else if (tick) begin
      hsync <= dly.hs;
      vsync <= dly.vs;
      {vga_r, vga_g, vga_b} <= dly.de ? bgr_split(rgb_in) : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: four configurations checked every clk against a
// raster-position model, plus literal timing points for the default mode.
module tb_vga_timing_ctrl;

  typedef struct packed {
    int   div;
    int   ha, hfp, hsw, hbp;
    int   va, vfp, vsw, vbp;
    int   lat;
    logic pol;
  } cfg_t;

  typedef struct packed {
    logic [9:0] px;
    logic [8:0] py;
    logic       valid, fs, hs, vs;
    logic [3:0] r, g, b;
  } exp_t;

  // 0: small raster /4 lat1, 1: small /1 lat0, 2: small /2 lat3 active-high, 3: real 640x480.
  function automatic cfg_t get_cfg(input int i);
    case (i)
      0:       return '{4, 16, 2, 3, 3, 6, 1, 2, 1, 1, 1'b0};
      1:       return '{1, 16, 2, 3, 3, 6, 1, 2, 1, 0, 1'b0};
      2:       return '{2, 16, 2, 3, 3, 6, 1, 2, 1, 3, 1'b1};
      default: return '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0};
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rgb_in;

  logic [9:0] px [4];
  logic [8:0] py [4];
  logic       pv [4];
  logic       fs [4];
  logic       hs [4];
  logic       vs [4];
  logic [3:0] vr [4];
  logic [3:0] vg [4];
  logic [3:0] vb [4];

  int checks = 0;
  int errors = 0;
  int e = 0;
  logic [11:0] rgb_last [4];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam cfg_t C = get_cfg(g);
      vga_timing_ctrl #(
        .CLK_DIV  (C.div),
        .H_ACTIVE (C.ha), .H_FP (C.hfp), .H_SYNC (C.hsw), .H_BP (C.hbp),
        .V_ACTIVE (C.va), .V_FP (C.vfp), .V_SYNC (C.vsw), .V_BP (C.vbp),
        .PIPE_LAT (C.lat),
        .SYNC_POL (C.pol)
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rgb_in      (rgb_in),
        .pix_x       (px[g]),
        .pix_y       (py[g]),
        .pix_valid   (pv[g]),
        .frame_start (fs[g]),
        .hsync       (hs[g]),
        .vsync       (vs[g]),
        .vga_r       (vr[g]),
        .vga_g       (vg[g]),
        .vga_b       (vb[g])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs after e clk edges since reset release, from raster position alone.
  function automatic exp_t model(input cfg_t c, input int edges, input logic [11:0] rgb);
    exp_t x;
    int ht, vt, tot, k, pos, h, v, d, p, ph, pl;
    ht  = c.ha + c.hfp + c.hsw + c.hbp;
    vt  = c.va + c.vfp + c.vsw + c.vbp;
    tot = ht * vt;
    k   = edges / c.div;
    pos = k % tot;
    h   = pos % ht;
    v   = pos / ht;
    x.valid = (h < c.ha) && (v < c.va);
    x.px    = x.valid ? 10'(h) : 10'd0;
    x.py    = x.valid ? 9'(v) : 9'd0;
    x.fs    = (edges > 0) && (edges % c.div == 0) && (pos == c.va * ht);
    x.hs    = ~c.pol;
    x.vs    = ~c.pol;
    x.r     = 4'h0;
    x.g     = 4'h0;
    x.b     = 4'h0;
    d = c.lat + 1;
    if (k >= d) begin
      p  = (k - d) % tot;
      ph = p % ht;
      pl = p / ht;
      if (ph >= c.ha + c.hfp && ph < c.ha + c.hfp + c.hsw) x.hs = c.pol;
      if (pl >= c.va + c.vfp && pl < c.va + c.vfp + c.vsw) x.vs = c.pol;
      if (ph < c.ha && pl < c.va) begin
        x.r = rgb[3:0];
        x.g = rgb[7:4];
        x.b = rgb[11:8];
      end
    end
    return x;
  endfunction

  // Per-clk compare of every instance against the model.
  always @(posedge clk) begin
    if (!rst_n) begin
      e = 0;
    end else begin
      e++;
      for (int i = 0; i < 4; i++)
        if (e % get_cfg(i).div == 0) rgb_last[i] = rgb_in;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_t act, ex;
      act.px = px[i]; act.py = py[i]; act.valid = pv[i]; act.fs = fs[i];
      act.hs = hs[i]; act.vs = vs[i]; act.r = vr[i]; act.g = vg[i]; act.b = vb[i];
      ex = model(get_cfg(i), e, rgb_last[i]);
      check($sformatf("dut%0d_e%0d", i, e), 64'(act), 64'(ex));
    end
  end

  logic [11:0] tbl [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'h123, 12'hABC, 12'h000, 12'hFFF, 12'h5A5};
  int hfall[$];
  int hrise[$];
  int fs_times[$];
  int fs_high;
  int refall;
  logic prev_hs, prev_fs;

  initial begin
    for (int i = 0; i < 4; i++) rgb_last[i] = '0;
    rst_n  = 1'b0;
    rgb_in = 12'hF00;
    repeat (4) @(negedge clk);
    check("rst_hsync",  64'(hs[3]), 64'd1);
    check("rst_vsync",  64'(vs[3]), 64'd1);
    check("rst_valid",  64'(pv[3]), 64'd1);
    check("rst_pix_x",  64'(px[3]), 64'd0);
    check("rst_colour", 64'({vr[3], vg[3], vb[3]}), 64'd0);
    check("rst_fs",     64'(fs[3]), 64'd0);
    check("rst_hsync_active_high", 64'(hs[2]), 64'd0);
    rst_n = 1'b1;

    prev_hs = 1'b1;
    prev_fs = 1'b0;
    fs_high = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #2;
      if (!hs[3] && prev_hs) hfall.push_back(e);
      if (hs[3] && !prev_hs) hrise.push_back(e);
      if (fs[0]) fs_high++;
      if (fs[0] && !prev_fs) fs_times.push_back(e);
      prev_hs = hs[3];
      prev_fs = fs[0];
      if (e == 1)  check("div1_lat0_first_colour", 64'({vr[1], vg[1], vb[1]}), 64'h00F);
      if (e == 7)  check("lat3_before_colour", 64'(vb[2]), 64'h0);
      if (e == 8)  check("lat3_first_colour", 64'(vb[2]), 64'hF);
      if (e == 63) check("small_last_active_x", 64'(px[0]), 64'd15);
      if (e == 64) check("small_valid_falls", 64'(pv[0]), 64'd0);
    end
    check("hsync_falls_seen", 64'(hfall.size() >= 2 && hrise.size() >= 1), 64'd1);
    if (hfall.size() >= 2 && hrise.size() >= 1) begin
      check("hsync_first_fall", 64'(hfall[0]), 64'd2632);
      check("hsync_low_clk", 64'(hrise[0] - hfall[0]), 64'd384);
      check("hsync_period_clk", 64'(hfall[1] - hfall[0]), 64'd3200);
    end
    check("frame_start_pulses", 64'(fs_times.size()), 64'd6);
    check("frame_start_high_clks", 64'(fs_high), 64'd6);
    if (fs_times.size() >= 2) begin
      check("frame_start_first", 64'(fs_times[0]), 64'd576);
      check("frame_start_period", 64'(fs_times[1] - fs_times[0]), 64'd960);
    end

    for (int c = 0; c < 4000 && e < 7600; c++) begin
      @(negedge clk);
      rgb_in = tbl[c % 8];
    end
    check("pre_reset_x", 64'(px[3]), 64'd300);
    check("pre_reset_y", 64'(py[3]), 64'd2);
    rst_n  = 1'b0;
    rgb_in = 12'hF00;
    #1;
    check("midrst_hsync",  64'(hs[3]), 64'd1);
    check("midrst_vsync",  64'(vs[3]), 64'd1);
    check("midrst_pix",    64'({px[3], py[3]}), 64'd0);
    check("midrst_colour", 64'({vr[3], vg[3], vb[3]}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    refall  = -1;
    prev_hs = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (!hs[3] && prev_hs && refall < 0) refall = e;
      prev_hs = hs[3];
    end
    check("post_reset_first_fall", 64'(refall), 64'd2632);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
